// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, nop encoding and the in-flight entry type for the fetch stage.
// An entry is one fetched word: a valid flag, its PC and the instruction bits.
// The req entry (word arriving on imem_q) and the skid slot both use this type.
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;

  typedef struct packed {
    logic               valid;
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_slot.sv
// fetch_skid_slot: one-entry hold register that parks a fetched word while decode stalls.
// Latency: the loaded entry appears on o_entry the cycle after i_load/i_consume.
// Backpressure: i_clear (squash) wins over load/consume; with no control the slot holds.
module fetch_skid_slot
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clear,
  input  logic         i_load,
  input  logic         i_consume,
  input  fetch_entry_t i_entry,
  output fetch_entry_t o_entry
);

  fetch_entry_t r_entry;

  // Slot register: squash, capture a stalled word, or refill from req as the held word leaves.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_entry <= '0;
    end else if (i_load || i_consume) begin
      // On consume the incoming entry may be invalid, which empties the slot.
      r_entry <= i_entry;
    end
  end

  assign o_entry = r_entry;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner, sync-imem driver and F/D latch writer with a one-entry skid slot.
// Latency: word fetched at cycle t is presented at t+1; redirect costs one bubble.
// Backpressure: stall holds the F/D latch; at most two words (hold + req) in flight.
// Optional build macro FETCH_PERF_COUNT_EN adds saturating perf_fetched/perf_bubbles counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int          IMEM_ADDR_W = 12,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_target,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  input  logic [31:0]            imem_q,
  output logic [31:0]            fd_pc_plus_1,
  output logic [31:0]            fd_instruction,
  output logic                   fd_enable,
  output logic                   fd_flush
`ifdef FETCH_PERF_COUNT_EN
 ,output logic [31:0]            perf_fetched,
  output logic [31:0]            perf_bubbles
`endif
);

  logic [PC_W-1:0] r_pc;
  logic            r_req_valid;
  logic [PC_W-1:0] r_req_pc;

  fetch_entry_t w_req;
  fetch_entry_t w_hold;
  fetch_entry_t w_src;
  logic         w_issue;
  logic         w_load;
  logic         w_consume;

  // The req word's instruction bits are whatever the ROM returns this cycle.
  always_comb begin
    w_req       = '0;
    w_req.valid = r_req_valid;
    w_req.pc    = r_req_pc;
    w_req.instr = imem_q;
  end

  // Only issue a new fetch when the hold slot can absorb the req word if decode stalls.
  assign w_issue   = !stall || !w_hold.valid;
  assign w_load    = stall && !w_hold.valid && r_req_valid;
  assign w_consume = !stall && w_hold.valid;

  fetch_skid_slot u_skid (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (redirect_valid),
    .i_load    (w_load),
    .i_consume (w_consume),
    .i_entry   (w_req),
    .o_entry   (w_hold)
  );

  // Output source: oldest valid word (hold, then req), nop otherwise or during reset.
  always_comb begin
    w_src = '0;
    if (reset) begin
      w_src = '0;
    end else if (w_hold.valid) begin
      w_src = w_hold;
    end else if (w_req.valid) begin
      w_src = w_req;
    end
  end

  assign fd_instruction = w_src.valid ? w_src.instr : NOP_INSTR;
  assign fd_pc_plus_1   = w_src.valid ? (w_src.pc + 32'd1) : 32'd0;
  assign fd_enable      = !stall || redirect_valid;
  assign fd_flush       = reset || redirect_valid;

  // ROM address: redirect target beats stall; a blocked issue re-reads req_pc so imem_q stays put.
  always_comb begin
    imem_addr = r_pc[IMEM_ADDR_W-1:0];
    if (reset) begin
      imem_addr = RESET_PC[IMEM_ADDR_W-1:0];
    end else if (redirect_valid) begin
      imem_addr = redirect_target[IMEM_ADDR_W-1:0];
    end else if (w_issue) begin
      imem_addr = r_pc[IMEM_ADDR_W-1:0];
    end else begin
      imem_addr = r_req_pc[IMEM_ADDR_W-1:0];
    end
  end

  // PC and req tracking: the req entry names the word the ROM returns next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc        <= RESET_PC;
      r_req_valid <= 1'b0;
      r_req_pc    <= '0;
    end else if (redirect_valid) begin
      r_req_valid <= 1'b1;
      r_req_pc    <= redirect_target;
      r_pc        <= redirect_target + 32'd1;
    end else if (w_issue) begin
      r_req_valid <= 1'b1;
      r_req_pc    <= r_pc;
      r_pc        <= r_pc + 32'd1;
    end
  end

`ifdef FETCH_PERF_COUNT_EN
  logic w_count_en;
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_bubbles;

  // Only cycles that actually write the F/D latch count; flushed cycles are ignored.
  assign w_count_en = fd_enable && !fd_flush;

  // Saturating counters for delivered words and delivered bubbles.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_fetched <= '0;
      r_perf_bubbles <= '0;
    end else if (w_count_en) begin
      if (w_src.valid) begin
        if (r_perf_fetched != 32'hFFFF_FFFF) r_perf_fetched <= r_perf_fetched + 32'd1;
      end else begin
        if (r_perf_bubbles != 32'hFFFF_FFFF) r_perf_bubbles <= r_perf_bubbles + 32'd1;
      end
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_bubbles = r_perf_bubbles;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with a queue-based reference model.
// The model tracks in-flight PCs in a queue (oldest presented first, at most two).
// Hand-computed literals at key cycles pin the model and the DUT together.
module tb_fetch_unit;

  localparam int          AW       = 12;
  localparam logic [31:0] RST_PC   = 32'h0;

  logic          clk;
  logic          reset;
  logic          stall;
  logic          redirect_valid;
  logic [31:0]   redirect_target;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_q;
  logic [31:0]   fd_pc_plus_1;
  logic [31:0]   fd_instruction;
  logic          fd_enable;
  logic          fd_flush;
`ifdef FETCH_PERF_COUNT_EN
  logic [31:0]   perf_fetched;
  logic [31:0]   perf_bubbles;
`endif

  int checks   = 0;
  int failures = 0;
  bit run      = 0;

  fetch_unit #(.IMEM_ADDR_W(AW), .RESET_PC(RST_PC)) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_addr       (imem_addr),
    .imem_q          (imem_q),
    .fd_pc_plus_1    (fd_pc_plus_1),
    .fd_instruction  (fd_instruction),
    .fd_enable       (fd_enable),
    .fd_flush        (fd_flush)
`ifdef FETCH_PERF_COUNT_EN
   ,.perf_fetched    (perf_fetched),
    .perf_bubbles    (perf_bubbles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [AW-1:0] a);
    return 32'h1000 + {20'h0, a};
  endfunction

  // Synchronous ROM: data for this cycle's address appears next cycle.
  always @(posedge clk) imem_q <= rom(imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: queue of PCs in flight plus the next fetch PC.
  logic [31:0] mq[$];
  logic [31:0] mpc;

  always @(posedge clk) begin
    bit push;
    bit pop;
    if (reset) begin
      mq.delete();
      mpc = RST_PC;
    end else if (redirect_valid) begin
      mq.delete();
      mq.push_back(redirect_target);
      mpc = redirect_target + 32'd1;
    end else begin
      push = (mq.size() < 2) || !stall;
      pop  = !stall && (mq.size() > 0);
      if (pop) void'(mq.pop_front());
      if (push) begin
        mq.push_back(mpc);
        mpc = mpc + 32'd1;
      end
    end
  end

  // Every-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    logic [31:0] e_instr, e_pp1, e_addr;
    if (run) begin
      e_instr = 32'h0;
      e_pp1   = 32'h0;
      if (reset) begin
        e_addr = {20'h0, RST_PC[AW-1:0]};
      end else begin
        if (mq.size() > 0) begin
          e_instr = rom(mq[0][AW-1:0]);
          e_pp1   = mq[0] + 32'd1;
        end
        if (redirect_valid)                 e_addr = {20'h0, redirect_target[AW-1:0]};
        else if (mq.size() < 2 || !stall)   e_addr = {20'h0, mpc[AW-1:0]};
        else                                e_addr = {20'h0, mq[mq.size()-1][AW-1:0]};
      end
      check("m_instr", fd_instruction, e_instr);
      check("m_pc_plus_1", fd_pc_plus_1, e_pp1);
      check("m_imem_addr", {20'h0, imem_addr}, e_addr);
      check("m_enable", {31'h0, fd_enable}, {31'h0, (!stall || redirect_valid)});
      check("m_flush", {31'h0, fd_flush}, {31'h0, (reset || redirect_valid)});
    end
  end

  // Drive one cycle's inputs just after the edge, then let outputs settle.
  task automatic cyc(input logic s, input logic rv, input logic [31:0] tgt, input logic rst);
    @(posedge clk);
    #1;
    stall           = s;
    redirect_valid  = rv;
    redirect_target = tgt;
    reset           = rst;
    #2;
  endtask

  logic [31:0] stall_pat;
  logic [31:0] redir_pat;

  initial begin
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
    cyc(0, 0, 0, 1);
    run = 1;
    cyc(0, 0, 0, 1);
    check("rst_flush", {31'h0, fd_flush}, 32'h1);
    check("rst_instr", fd_instruction, 32'h0);
    check("rst_addr", {20'h0, imem_addr}, 32'h0);

    // cycle 0: nop with enable
    cyc(0, 0, 0, 0);
    check("c0_instr", fd_instruction, 32'h0);
    check("c0_pp1", fd_pc_plus_1, 32'h0);
    check("c0_enable", {31'h0, fd_enable}, 32'h1);
    // cycle 1: first word
    cyc(0, 0, 0, 0);
    check("c1_instr", fd_instruction, 32'h1000);
    check("c1_pp1", fd_pc_plus_1, 32'h1);
    for (int i = 2; i <= 5; i++) cyc(0, 0, 0, 0);
    check("c5_instr", fd_instruction, 32'h1004);

    // cycles 6..8: stall
    cyc(1, 0, 0, 0);
    check("c6_enable", {31'h0, fd_enable}, 32'h0);
    check("c6_instr", fd_instruction, 32'h1005);
    cyc(1, 0, 0, 0);
    check("c7_enable", {31'h0, fd_enable}, 32'h0);
    cyc(1, 0, 0, 0);
    check("c8_instr", fd_instruction, 32'h1005);
    cyc(0, 0, 0, 0);
    check("c9_instr", fd_instruction, 32'h1005);
    check("c9_enable", {31'h0, fd_enable}, 32'h1);
    cyc(0, 0, 0, 0);
    check("c10_instr", fd_instruction, 32'h1006);
    check("c10_pp1", fd_pc_plus_1, 32'h7);

    // cycle 11: redirect to 0x40 while word 7 is presented
    cyc(0, 1, 32'h40, 0);
    check("c11_flush", {31'h0, fd_flush}, 32'h1);
    check("c11_instr", fd_instruction, 32'h1007);
    check("c11_addr", {20'h0, imem_addr}, 32'h40);
    cyc(0, 0, 0, 0);
    check("c12_instr", fd_instruction, 32'h1040);
    check("c12_pp1", fd_pc_plus_1, 32'h41);
    check("c12_flush", {31'h0, fd_flush}, 32'h0);

    // cycle 13 stall fills hold; cycle 14 stall + redirect to 0x20
    cyc(1, 0, 0, 0);
    check("c13_instr", fd_instruction, 32'h1041);
    cyc(1, 1, 32'h20, 0);
    check("c14_enable", {31'h0, fd_enable}, 32'h1);
    check("c14_flush", {31'h0, fd_flush}, 32'h1);
    check("c14_instr", fd_instruction, 32'h1041);
    cyc(0, 0, 0, 0);
    check("c15_instr", fd_instruction, 32'h1020);
    check("c15_pp1", fd_pc_plus_1, 32'h21);

    // reset mid-stall with hold full
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 1);
    check("mrst_instr", fd_instruction, 32'h0);
    check("mrst_flush", {31'h0, fd_flush}, 32'h1);
    cyc(0, 0, 0, 0);
    check("mrst_c0_instr", fd_instruction, 32'h0);
    cyc(0, 0, 0, 0);
    check("mrst_c1_instr", fd_instruction, rom(RST_PC[AW-1:0]));
    check("mrst_c1_pp1", fd_pc_plus_1, RST_PC + 32'd1);

    // PC wrap at 32'hFFFFFFFF
    cyc(0, 1, 32'hFFFF_FFFF, 0);
    check("wrap_addr", {20'h0, imem_addr}, 32'hFFF);
    cyc(0, 0, 0, 0);
    check("wrap_instr", fd_instruction, 32'h1FFF);
    check("wrap_pp1", fd_pc_plus_1, 32'h0);
    cyc(0, 0, 0, 0);
    check("wrap_next_instr", fd_instruction, 32'h1000);
    check("wrap_next_pp1", fd_pc_plus_1, 32'h1);

    // Mixed stall/redirect pattern, checked by the model only
    stall_pat = 32'b0110_1110_0011_1001_1110_0100_1111_0010;
    redir_pat = 32'b0000_0100_0000_0010_0000_1000_0000_0000;
    for (int i = 0; i < 32; i++)
      cyc(stall_pat[i], redir_pat[i], 32'h300 + i, 0);

    // Counter segment: reset, 10 clean cycles, then one redirect
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0);
    cyc(0, 1, 32'h80, 0);
    cyc(0, 0, 0, 0);
    check("post_redir_instr", fd_instruction, 32'h1080);
`ifdef FETCH_PERF_COUNT_EN
    check("perf_bubbles", perf_bubbles, 32'd1);
    check("perf_fetched", perf_fetched, 32'd9);
`endif
    cyc(0, 0, 0, 0);
    run = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
